// File: rtl/decoder_mc_if.sv
// Instruction/control bundle between fetch, decoder and datapath.
// master = fetch side (drives instruction), slave = decoder.
interface decoder_mc_if;
    logic [31:0] instruction;
    logic [3:0]  AluOp;
    logic        regw;
    logic [2:0]  imm;
    logic [1:0]  writesel;
    logic        asel;
    logic        ramR;
    logic        ramW;
    logic [1:0]  pcsel;
    logic        pc_en;
    logic        busy;
    logic        illegal;

    modport master (
        output instruction,
        input  AluOp, regw, imm, writesel, asel, ramR, ramW, pcsel, pc_en, busy, illegal
    );
    modport slave (
        input  instruction,
        output AluOp, regw, imm, writesel, asel, ramR, ramW, pcsel, pc_en, busy, illegal
    );
endinterface

// File: rtl/decoder_mc.sv
// Multi-cycle RV32I control decoder; loads stall the PC for LOAD_LAT cycles.
// Optional ILLEGAL_TRAP_EN: unlisted opcodes trap and set a sticky illegal flag.
module decoder_mc #(
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic         clock,
    input  logic         reset,
    decoder_mc_if.slave  bus
);
    localparam int unsigned CW = $clog2(LOAD_LAT + 1);

    localparam logic [6:0] OpR     = 7'b0110011;
    localparam logic [6:0] OpIAlu  = 7'b0010011;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpAuipc = 7'b0010111;
    localparam logic [6:0] OpJalr  = 7'b1100111;
    localparam logic [6:0] OpBr    = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;

    typedef struct packed {
        logic [3:0] aluop;
        logic       regw;
        logic [2:0] imm;
        logic [1:0] writesel;
        logic       asel;
        logic       ramr;
        logic       ramw;
        logic [1:0] pcsel;
    } ctrl_t;

    localparam ctrl_t LoadCtrl = '{aluop: 4'b0000, regw: 1'b0, imm: 3'b001, writesel: 2'b01,
                                   asel: 1'b0, ramr: 1'b1, ramw: 1'b0, pcsel: 2'b00};

    typedef enum logic [1:0] {
        StExec,
        StLwait
`ifdef ILLEGAL_TRAP_EN
        , StTrap
`endif
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7b5;
    ctrl_t      dec, ctrl;
    logic       is_load, is_known;
    logic       pc_en, busy;

    assign opcode = bus.instruction[6:0];
    assign funct3 = bus.instruction[14:12];
    assign f7b5   = bus.instruction[30];

    logic unused_instr;
    assign unused_instr = ^{bus.instruction[31], bus.instruction[29:15], bus.instruction[11:7]};

    always_comb begin
        dec      = '0;
        is_load  = 1'b0;
        is_known = 1'b1;
        case (opcode)
            OpR: begin
                dec.aluop = {funct3, f7b5};
                dec.regw  = 1'b1;
            end
            OpIAlu: begin
                dec.regw = 1'b1;
                // Only shifts carry funct7[5] (srai vs srli).
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec.aluop = {funct3, f7b5};
                    dec.imm   = 3'b010;
                end else begin
                    dec.aluop = {funct3, 1'b0};
                    dec.imm   = 3'b001;
                end
            end
            OpLoad: begin
                dec     = LoadCtrl;
                is_load = 1'b1;
            end
            OpStore: begin
                dec.imm  = 3'b011;
                dec.ramw = 1'b1;
            end
            OpLui: begin
                dec.imm  = 3'b100;
                dec.regw = 1'b1;
            end
            OpAuipc: begin
                dec.imm  = 3'b100;
                dec.asel = 1'b1;
                dec.regw = 1'b1;
            end
            OpJalr: begin
                dec.imm      = 3'b001;
                dec.pcsel    = 2'b01;
                dec.regw     = 1'b1;
                dec.writesel = 2'b10;
            end
            OpBr: begin
                dec.imm   = 3'b101;
                dec.pcsel = 2'b10;
                dec.aluop = {funct3, 1'b0};
            end
            OpJal: begin
                dec.imm      = 3'b110;
                dec.pcsel    = 2'b11;
                dec.regw     = 1'b1;
                dec.writesel = 2'b10;
            end
            default: is_known = 1'b0;
        endcase
    end

    // State register
`ifdef ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
`endif
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StExec;
            cnt_q     <= '0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
`ifdef ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            StExec: begin
                if (is_load) begin
                    state_d = StLwait;
                    cnt_d   = CW'(LOAD_LAT - 1);
                end
`ifdef ILLEGAL_TRAP_EN
                else if (!is_known) begin
                    state_d   = StTrap;
                    illegal_d = 1'b1;
                end
`endif
            end
            StLwait: begin
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                else             state_d = StExec;
            end
`ifdef ILLEGAL_TRAP_EN
            StTrap: state_d = StTrap;
`endif
            default: state_d = StExec;
        endcase
    end

    // Output logic; reset forces every output low.
    always_comb begin
        ctrl  = '0;
        pc_en = 1'b0;
        busy  = 1'b0;
        if (!reset) begin
            case (state_q)
                StExec: begin
                    ctrl  = dec;
                    busy  = is_load;
`ifdef ILLEGAL_TRAP_EN
                    pc_en = !is_load && is_known;
`else
                    pc_en = !is_load;
`endif
                end
                StLwait: begin
                    ctrl      = LoadCtrl;
                    ctrl.regw = (cnt_q == '0);
                    pc_en     = (cnt_q == '0);
                    busy      = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef ILLEGAL_TRAP_EN
    assign bus.illegal = illegal_q & ~reset;
`else
    logic unused_known;
    assign unused_known = is_known;
    assign bus.illegal  = 1'b0;
`endif

    assign bus.AluOp    = ctrl.aluop;
    assign bus.regw     = ctrl.regw;
    assign bus.imm      = ctrl.imm;
    assign bus.writesel = ctrl.writesel;
    assign bus.asel     = ctrl.asel;
    assign bus.ramR     = ctrl.ramr;
    assign bus.ramW     = ctrl.ramw;
    assign bus.pcsel    = ctrl.pcsel;
    assign bus.pc_en    = pc_en;
    assign bus.busy     = busy;
endmodule

// File: tb/tb_decoder_mc.sv
// Directed bench for decoder_mc: two instances (LOAD_LAT=3 and LOAD_LAT=1) on one clock.
module tb_decoder_mc;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    decoder_mc_if bus3 ();
    decoder_mc_if bus1 ();

    decoder_mc #(.LOAD_LAT(3)) u_dut3 (.clock(clock), .reset(reset), .bus(bus3));
    decoder_mc #(.LOAD_LAT(1)) u_dut1 (.clock(clock), .reset(reset), .bus(bus1));

    localparam logic [31:0] IAddi  = 32'h00A00513;
    localparam logic [31:0] IAdd   = 32'h00B50533;
    localparam logic [31:0] ISub   = 32'h40B50533;
    localparam logic [31:0] ISrai  = 32'h40355513;
    localparam logic [31:0] IAndi  = 32'h4FF57513;
    localparam logic [31:0] ISw    = 32'h00A52023;
    localparam logic [31:0] ILui   = 32'h123452B7;
    localparam logic [31:0] IAuipc = 32'h00001517;
    localparam logic [31:0] IJal   = 32'h008000EF;
    localparam logic [31:0] IJalr  = 32'h000080E7;
    localparam logic [31:0] IBne   = 32'h00B51463;
    localparam logic [31:0] ILw    = 32'h00052503;
    localparam logic [31:0] IIll   = 32'h0000007F;

    // {AluOp, regw, imm, writesel, asel, ramR, ramW, pcsel, pc_en, busy, illegal}
    logic [17:0] v3, v1;
    assign v3 = {bus3.AluOp, bus3.regw, bus3.imm, bus3.writesel, bus3.asel, bus3.ramR,
                 bus3.ramW, bus3.pcsel, bus3.pc_en, bus3.busy, bus3.illegal};
    assign v1 = {bus1.AluOp, bus1.regw, bus1.imm, bus1.writesel, bus1.asel, bus1.ramR,
                 bus1.ramW, bus1.pcsel, bus1.pc_en, bus1.busy, bus1.illegal};

    function automatic logic [17:0] ev(input logic [3:0] a, input logic r, input logic [2:0] im,
                                       input logic [1:0] ws, input logic as, input logic rr,
                                       input logic rw, input logic [1:0] pc, input logic pe,
                                       input logic bz, input logic il);
        return {a, r, im, ws, as, rr, rw, pc, pe, bz, il};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic apply(input logic [31:0] i3, input logic [31:0] i1);
        bus3.instruction = i3;
        bus1.instruction = i1;
    endtask

    task automatic both(input string tag, input logic [31:0] instr, input logic [17:0] exp);
        next_cycle();
        apply(instr, instr);
        @(negedge clock);
        check({tag, "_l3"}, 32'(v3), 32'(exp));
        check({tag, "_l1"}, 32'(v1), 32'(exp));
    endtask

    logic [17:0] e_addi, e_lw_wait, e_lw_wb, e_zero;

    initial begin
        e_addi    = ev(4'b0000, 1, 3'b001, 2'b00, 0, 0, 0, 2'b00, 1, 0, 0);
        e_lw_wait = ev(4'b0000, 0, 3'b001, 2'b01, 0, 1, 0, 2'b00, 0, 1, 0);
        e_lw_wb   = ev(4'b0000, 1, 3'b001, 2'b01, 0, 1, 0, 2'b00, 1, 1, 0);
        e_zero    = '0;

        apply(IAddi, IAddi);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("reset_l3", 32'(v3), 32'(e_zero));
            check("reset_l1", 32'(v1), 32'(e_zero));
            next_cycle();
        end
        reset = 1'b0;
        @(negedge clock);
        check("post_reset_addi", 32'(v3), 32'(e_addi));

        both("add",   IAdd,   ev(4'b0000, 1, 3'b000, 2'b00, 0, 0, 0, 2'b00, 1, 0, 0));
        both("sub",   ISub,   ev(4'b0001, 1, 3'b000, 2'b00, 0, 0, 0, 2'b00, 1, 0, 0));
        both("srai",  ISrai,  ev(4'b1011, 1, 3'b010, 2'b00, 0, 0, 0, 2'b00, 1, 0, 0));
        both("andi",  IAndi,  ev(4'b1110, 1, 3'b001, 2'b00, 0, 0, 0, 2'b00, 1, 0, 0));
        both("sw",    ISw,    ev(4'b0000, 0, 3'b011, 2'b00, 0, 0, 1, 2'b00, 1, 0, 0));
        both("lui",   ILui,   ev(4'b0000, 1, 3'b100, 2'b00, 0, 0, 0, 2'b00, 1, 0, 0));
        both("auipc", IAuipc, ev(4'b0000, 1, 3'b100, 2'b00, 1, 0, 0, 2'b00, 1, 0, 0));
        both("jal",   IJal,   ev(4'b0000, 1, 3'b110, 2'b10, 0, 0, 0, 2'b11, 1, 0, 0));
        both("jalr",  IJalr,  ev(4'b0000, 1, 3'b001, 2'b10, 0, 0, 0, 2'b01, 1, 0, 0));
        both("bne",   IBne,   ev(4'b0010, 0, 3'b101, 2'b00, 0, 0, 0, 2'b10, 1, 0, 0));

        // Load issue at t on both instances.
        both("lw_t0", ILw, e_lw_wait);
        next_cycle();
        @(negedge clock);
        check("lw_t1_l3", 32'(v3), 32'(e_lw_wait));
        check("lw_t1_l1_wb", 32'(v1), 32'(e_lw_wb));
        next_cycle();
        apply(ILw, IAdd);
        @(negedge clock);
        check("lw_t2_l3", 32'(v3), 32'(e_lw_wait));
        check("lw_t2_l1_next", 32'(v1),
              32'(ev(4'b0000, 1, 3'b000, 2'b00, 0, 0, 0, 2'b00, 1, 0, 0)));
        next_cycle();
        @(negedge clock);
        check("lw_t3_l3_wb", 32'(v3), 32'(e_lw_wb));
        next_cycle();
        apply(IAddi, IAddi);
        @(negedge clock);
        check("lw_t4_l3_next", 32'(v3), 32'(e_addi));

        // Reset one cycle into a LOAD_LAT=3 load.
        both("rst_lw_t0", ILw, e_lw_wait);
        next_cycle();
        reset = 1'b1;
        apply(IAddi, IAddi);
        @(negedge clock);
        check("rst_lw_t1_zero", 32'(v3), 32'(e_zero));
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        check("rst_lw_t2_exec", 32'(v3), 32'(e_addi));
        next_cycle();
        @(negedge clock);
        check("rst_lw_t3_exec", 32'(v3), 32'(e_addi));

        // Unlisted opcode.
`ifdef ILLEGAL_TRAP_EN
        both("ill_issue", IIll, e_zero);
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            apply(IAddi, IAddi);
            @(negedge clock);
            check("ill_trap_l3", 32'(v3), 32'(ev(4'b0, 0, 3'b0, 2'b0, 0, 0, 0, 2'b0, 0, 0, 1)));
        end
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        check("ill_cleared", 32'(v3), 32'(e_addi));
`else
        both("ill_nop", IIll, ev(4'b0, 0, 3'b0, 2'b0, 0, 0, 0, 2'b0, 1, 0, 0));
        next_cycle();
        apply(IAddi, IAddi);
        @(negedge clock);
        check("ill_after", 32'(v3), 32'(e_addi));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/decoder_mc.md
# decoder_mc

Parametrised multi-cycle successor to the single-cycle RV32I control decoder. Takes the full 32-bit instruction word from fetch and produces the same control bundle (AluOp, regw, imm, writesel, ramR, ramW, pcsel). It adds a state machine that stalls the PC for a configurable RAM read latency on loads, so load write-back occurs in a later cycle than issue. It sits between the instruction register and the datapath (ALU, register file, data RAM, PC mux).

## Interface
- LOAD_LAT, default 1: data-RAM read latency in cycles, legal range 1..15. A load occupies LOAD_LAT+1 cycles.
- CW, default $clog2(LOAD_LAT+1): wait-counter width. Derived, never overridden.
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- instruction  in  32  current instruction. Fetch holds it stable while pc_en=0.
- AluOp  out  4  {funct3, funct7[5]} encoding, as in the single-cycle decoder.
- regw  out  1  register-file write enable.
- imm  out  3  immediate select: 000 none, 001 I, 010 shamt, 011 S, 100 U, 101 B, 110 J.
- writesel  out  2  write-back source: 00 ALU, 01 RAM, 10 PC+4.
- asel  out  1  ALU operand-A select: 0 rs1, 1 PC. Set for auipc only.
- ramR  out  1  data-RAM read enable.
- ramW  out  1  data-RAM write enable.
- pcsel  out  2  next-PC source: 00 PC+4, 01 jalr, 10 branch, 11 jal.
- pc_en  out  1  PC/instruction-register advance enable.
- busy  out  1  high while a load is in progress.
- illegal  out  1  sticky illegal-opcode flag. Tied 0 unless ILLEGAL_TRAP_EN is defined.

## Operation
- Field extraction: opcode=[6:0], funct3=[14:12], funct7=[31:25].
- Opcode decode uses the standard RV32I values.
  - R 0110011: AluOp={f3,f7[5]}, regw=1, writesel=00.
  - I-ALU 0010011 with f3=001/101: AluOp={f3,f7[5]}, imm=010. Other f3 values: AluOp={f3,0}, imm=001. In both cases regw=1.
  - store 0100011: imm=011, ramW=1, regw=0.
  - lui 0110111: imm=100, regw=1.
  - auipc 0010111: imm=100, asel=1, regw=1.
  - jalr 1100111: imm=001, pcsel=01, regw=1, writesel=10.
  - branch 1100011: imm=101, pcsel=10, AluOp={f3,0}.
  - jal 1101111: imm=110, pcsel=11, regw=1, writesel=10. Note that jal does write its link register.
- Unlisted opcodes decode to all-zero controls.
- State machine states: EXEC, LWAIT, TRAP. TRAP exists only with the macro defined.
- EXEC, non-load instruction: decode is combinational, pc_en=1, busy=0. State stays EXEC.
- EXEC, load 0000011: outputs imm=001, AluOp=0000, ramR=1, writesel=01, regw=0, pc_en=0, busy=1. Counter loads LOAD_LAT-1. Next state is LWAIT.
- LWAIT: controls are held from the load issue cycle (ramR=1, writesel=01, imm=001), busy=1.
  - counter≠0: decrement, regw=0, pc_en=0.
  - counter==0: regw=1, pc_en=1. Next state is EXEC.
- Load-to-load: the second load is seen in EXEC on the cycle after write-back and follows the same sequence. No overlap between loads.
- Counter arithmetic is unsigned CW-bit and never wraps. It is only decremented while non-zero.

## Timing
- Reset (synchronous): next state EXEC, counter 0, illegal 0.
- While reset=1, every output is forced to 0, including pc_en and busy.
- Non-load instructions: zero added latency, one instruction per cycle.
- Load: issue at cycle t. Write-back (regw=1) and pc_en=1 at cycle t+LOAD_LAT. Next instruction decoded at t+LOAD_LAT+1.
- ramW is never asserted in the same cycle as ramR.
- Reset asserted mid-load: takes priority. The FSM returns to EXEC on the next edge, and no regw pulse is issued for the aborted load.
- The instruction input changing during LWAIT is a protocol violation. Decode ignores the input until EXEC.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - An unlisted opcode in EXEC drives all controls to 0 and pc_en=0 in that cycle.
  - Next state is TRAP, and illegal=1 from the following cycle.
  - TRAP holds all controls at 0 and pc_en=0. Only reset leaves TRAP.
- ILLEGAL_TRAP_EN undefined:
  - An unlisted opcode executes as a NOP: all-zero controls, pc_en=1.
  - There is no TRAP state, and illegal is constant 0.

## Test plan
- Reset: hold reset=1 for 2 cycles with instruction=0x00A00513 (addi) → all outputs 0. After release: regw=1, imm=001, AluOp=0000, pc_en=1.
- add/sub: 0x00B50533 → AluOp=0000. Then 0x40B50533 → AluOp=0001. Both regw=1, writesel=00, one cycle each.
- Load with LOAD_LAT=3: lw 0x00052503 at t → ramR=1 on t..t+3, regw=1 and pc_en=1 only at t+3, busy=1 on t..t+3. Repeat with LOAD_LAT=1 → write-back at t+1.
- Reset mid-load: assert reset at t+1 of a LOAD_LAT=3 load → no regw pulse, EXEC at t+2, then a fresh decode.
- Jumps/upper: jal 0x008000EF → pcsel=11, regw=1, writesel=10, imm=110. auipc 0x00001517 → asel=1, imm=100.
- Illegal opcode 0x0000007F:
  - With ILLEGAL_TRAP_EN: pc_en=0, illegal=1 from the next cycle, remains 1 across 10 cycles, cleared by reset.
  - Without ILLEGAL_TRAP_EN: pc_en=1, all controls 0, illegal=0.
